cpu_mem_responder: RTL and testbench

//  Memory-side responder for the Cpu load/store/fetch interface. It accepts
//  the CPU's read/write request and splits 8/16/32/48-bit accesses into byte

---
 rtl/cpu_mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Purpose: memory-side responder for the CPU load/store/fetch port; splits 8/16/32/48-bit accesses into byte accesses on a byte-wide synchronous RAM.
// Latency: a read stalls the CPU for N+2 cycles and a write for N+1 cycles (N = 1,2,4,6 bytes); read data appears in the one-cycle DONE state.
// Backpressure: cpu_enable is held low while a transaction is in flight; requests presented in DONE are ignored.
module cpu_mem_responder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req_rd,
    input  logic              cpu_req_wr,
    input  logic [1:0]        cpu_req_sz,
    input  logic [31:0]       cpu_addr,
    input  logic [47:0]       cpu_data_out,
    output logic              cpu_enable,
    output logic [47:0]       cpu_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Latched request; the CPU bus is not assumed stable after acceptance.
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        nbytes;
    logic [47:0]       wdata_lat;

    // Byte counter: in RD it counts cycles (issue index and capture index + 1),
    // in WR it is the index of the byte currently on the RAM port.
    logic [2:0]        cnt;
    logic [2:0]        cnt_inc;
    logic [2:0]        last_idx;
    logic [ADDR_W-1:0] addr_next;

    // Read assembly register, filled one byte per cycle as RAM data returns.
    logic [47:0]       shadow;
    logic [47:0]       shadow_nxt;

    logic              req;

    // Upper address bits beyond the RAM size are deliberately ignored.
    generate
        if (ADDR_W < 32) begin : g_addr_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^cpu_addr[31:ADDR_W];
        end
    endgenerate

    // Number of bytes moved for each request size code.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            2'd2:    n = 3'd4;
            default: n = 3'd6;
        endcase
        return n;
    endfunction

    // Keeps the low n byte lanes of a 48-bit word, zeroes the rest.
    function automatic logic [47:0] lane_mask(input logic [2:0] n);
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) < n) begin
                m[8*i +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    // Selects byte lane idx of a 48-bit little-endian word.
    function automatic logic [7:0] byte_sel(input logic [47:0] d, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = d[7:0];
            3'd1:    b = d[15:8];
            3'd2:    b = d[23:16];
            3'd3:    b = d[31:24];
            3'd4:    b = d[39:32];
            default: b = d[47:40];
        endcase
        return b;
    endfunction

    assign req       = cpu_req_rd | cpu_req_wr;
    assign cnt_inc   = cnt + 3'd1;
    assign last_idx  = nbytes - 3'd1;
    // Byte addresses wrap modulo 2^ADDR_W by natural truncation of the add.
    assign addr_next = base_addr + {{(ADDR_W-3){1'b0}}, cnt_inc};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: reads take N+1 cycles in RD (one extra for RAM latency),
    // writes take N cycles in WR, DONE is always a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req_rd) begin
                    state_nxt = RD;
                end else if (cpu_req_wr) begin
                    state_nxt = WR;
                end
            end
            RD: begin
                if (cnt == nbytes) begin
                    state_nxt = DONE;
                end
            end
            WR: begin
                if (cnt == last_idx) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CPU stall output; forced low while reset is asserted.
    always_comb begin
        cpu_enable = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE:    cpu_enable = !req;
                DONE:    cpu_enable = 1'b1;
                default: cpu_enable = 1'b0;
            endcase
        end
    end

    // Merge the byte returned by the RAM into the read assembly register;
    // the byte arriving in RD cycle k belongs to lane k-1.
    always_comb begin
        shadow_nxt = shadow;
        if (state == RD && cnt != 3'd0) begin
            case (cnt)
                3'd1:    shadow_nxt[7:0]   = mem_rdata;
                3'd2:    shadow_nxt[15:8]  = mem_rdata;
                3'd3:    shadow_nxt[23:16] = mem_rdata;
                3'd4:    shadow_nxt[31:24] = mem_rdata;
                3'd5:    shadow_nxt[39:32] = mem_rdata;
                default: shadow_nxt[47:40] = mem_rdata;
            endcase
        end
    end

    // Datapath: request latch, byte counter, registered RAM port and read result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_addr   <= '0;
            nbytes      <= 3'd0;
            wdata_lat   <= '0;
            cnt         <= 3'd0;
            shadow      <= '0;
            cpu_data_in <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= 3'd0;
                    mem_we <= 1'b0;
                    if (req) begin
                        base_addr <= cpu_addr[ADDR_W-1:0];
                        nbytes    <= size_to_bytes(cpu_req_sz);
                        wdata_lat <= cpu_data_out;
                        shadow    <= '0;
                        // Byte 0 goes out on the first RD/WR cycle.
                        mem_addr  <= cpu_addr[ADDR_W-1:0];
                        if (!cpu_req_rd) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= cpu_data_out[7:0];
                        end
                    end
                end
                RD: begin
                    cnt    <= cnt_inc;
                    shadow <= shadow_nxt;
                    if (cnt < last_idx) begin
                        mem_addr <= addr_next;
                    end
                    if (cnt == nbytes) begin
                        cpu_data_in <= shadow_nxt & lane_mask(nbytes);
                    end
                end
                WR: begin
                    if (cnt == last_idx) begin
                        mem_we <= 1'b0;
                    end else begin
                        cnt       <= cnt_inc;
                        mem_addr  <= addr_next;
                        mem_wdata <= byte_sel(wdata_lat, cnt_inc);
                    end
                end
                default: begin
                    cnt    <= 3'd0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req_rd;
    logic        cpu_req_wr;
    logic [1:0]  cpu_req_sz;
    logic [31:0] cpu_addr;
    logic [47:0] cpu_data_out;
    logic        cpu_enable;
    logic [47:0] cpu_data_in;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    // Bench RAM driven by the DUT, with a backdoor port for preloading.
    logic [7:0]  ram [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [7:0]  bd_dat = '0;

    // Reference: expected RAM image and last completed read value.
    logic [7:0]  model [0:65535];
    logic [47:0] last_read;

    // Observations from the most recent transaction.
    logic [15:0] obs_waddr [0:7];
    logic [7:0]  obs_wdat  [0:7];
    logic [15:0] obs_raddr [0:7];

    always #5 clk = ~clk;

    cpu_mem_responder #(.ADDR_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req_rd   (cpu_req_rd),
        .cpu_req_wr   (cpu_req_wr),
        .cpu_req_sz   (cpu_req_sz),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_enable   (cpu_enable),
        .cpu_data_in  (cpu_data_in),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_dat;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic int nb(input logic [1:0] sz);
        int n;
        case (sz)
            2'd0: n = 1;
            2'd1: n = 2;
            2'd2: n = 4;
            default: n = 6;
        endcase
        return n;
    endfunction

    function automatic logic [47:0] model_read(input logic [15:0] a, input int n);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = model[16'(a + 16'(i))];
        return r;
    endfunction

    task automatic model_write(input logic [15:0] a, input int n, input logic [47:0] d);
        for (int i = 0; i < n; i++) model[16'(a + 16'(i))] = d[8*i +: 8];
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_dat = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        model[a] = d;
    endtask

    // Presents one request and observes it until the DONE cycle.
    // Entered and left at #1 after a rising edge.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [47:0] wd, input bit hold,
                           output int stall, output int we_n, output int we_bad,
                           output logic [47:0] res, output bit tmo);
        int nr;
        cpu_req_rd = rd; cpu_req_wr = wr; cpu_req_sz = sz; cpu_addr = a; cpu_data_out = wd;
        stall = 0; we_n = 0; we_bad = 0; nr = 0; tmo = 1'b1; res = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_enable) begin
                if (mem_we) we_bad++;
                res = cpu_data_in;
                tmo = 1'b0;
                break;
            end
            stall++;
            if (c == 0) begin
                if (mem_we) we_bad++;
            end else begin
                if (nr < 8) obs_raddr[nr] = mem_addr;
                nr++;
                if (mem_we) begin
                    if (we_n < 8) begin
                        obs_waddr[we_n] = mem_addr;
                        obs_wdat[we_n]  = mem_wdata;
                    end
                    we_n++;
                end
            end
        end
        @(posedge clk); #1;
        if (!hold) begin
            cpu_req_rd = 1'b0; cpu_req_wr = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req_rd = 1'b1; cpu_req_wr = 1'b1; cpu_req_sz = 2'd3;
        cpu_addr = 32'h1234; cpu_data_out = 48'hFFFF_FFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%0b exp=0", cpu_enable); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        total++; if (cpu_data_in !== 48'h0) begin bad++; $display("FAIL rst_data_in got=%h exp=0", cpu_data_in); end
        cpu_req_rd = 1'b0; cpu_req_wr = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_read = '0;
        @(negedge clk);
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL idle_enable got=%0b exp=1", cpu_enable); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_32();
        int st, wn, wb; logic [47:0] r; bit t;
        poke(16'h10, 8'h11); poke(16'h11, 8'h22); poke(16'h12, 8'h33); poke(16'h13, 8'h44);
        run_txn(1, 0, 2'd2, 32'h10, 48'h0, 0, st, wn, wb, r, t);
        total++; if (t || st != 6) begin bad++; $display("FAIL t1_stall got=%0d tmo=%0b exp=6", st, t); end
        total++; if (r !== 48'h000044332211) begin bad++; $display("FAIL t1_data got=%h exp=000044332211", r); end
        total++; if (wn != 0 || wb != 0) begin bad++; $display("FAIL t1_we got=%0d/%0d exp=0/0", wn, wb); end
        last_read = 48'h000044332211;
    endtask

    task automatic test_write_16();
        int st, wn, wb; logic [47:0] r; bit t;
        run_txn(0, 1, 2'd1, 32'h20, 48'h1234_5678_BEEF, 0, st, wn, wb, r, t);
        model_write(16'h20, 2, 48'h0000_0000_BEEF);
        total++; if (t || st != 3) begin bad++; $display("FAIL t2_stall got=%0d tmo=%0b exp=3", st, t); end
        total++; if (wn != 2 || wb != 0) begin bad++; $display("FAIL t2_we_cycles got=%0d bad=%0d exp=2/0", wn, wb); end
        total++; if (obs_waddr[0] !== 16'h20 || obs_waddr[1] !== 16'h21) begin bad++; $display("FAIL t2_addr got=%h,%h exp=0020,0021", obs_waddr[0], obs_waddr[1]); end
        total++; if (ram[16'h20] !== 8'hEF || ram[16'h21] !== 8'hBE) begin bad++; $display("FAIL t2_ram got=%h,%h exp=EF,BE", ram[16'h20], ram[16'h21]); end
        total++; if (ram[16'h22] !== model[16'h22]) begin bad++; $display("FAIL t2_untouched got=%h exp=%h", ram[16'h22], model[16'h22]); end
        total++; if (r !== last_read) begin bad++; $display("FAIL t2_data_hold got=%h exp=%h", r, last_read); end
    endtask

    task automatic test_wrap_48();
        int st, wn, wb; logic [47:0] r, e; bit t;
        e = model_read(16'hFFFE, 6);
        run_txn(1, 0, 2'd3, 32'hABCD_FFFE, 48'h0, 0, st, wn, wb, r, t);
        total++; if (t || st != 8) begin bad++; $display("FAIL t3_stall got=%0d tmo=%0b exp=8", st, t); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_raddr[i] !== 16'(16'hFFFE + 16'(i))) begin
                bad++; $display("FAIL t3_addr[%0d] got=%h exp=%h", i, obs_raddr[i], 16'(16'hFFFE + 16'(i)));
            end
        end
        total++; if (r !== e) begin bad++; $display("FAIL t3_data got=%h exp=%h", r, e); end
        last_read = e;
    endtask

    task automatic test_back_to_back();
        int st, wn, wb; logic [47:0] r, e; bit t;
        e = model_read(16'h5, 1);
        for (int k = 0; k < 2; k++) begin
            run_txn(1, 0, 2'd0, 32'h5, 48'h0, (k == 0), st, wn, wb, r, t);
            total++; if (t || st != 3) begin bad++; $display("FAIL t4_stall[%0d] got=%0d tmo=%0b exp=3", k, st, t); end
            total++; if (r !== e) begin bad++; $display("FAIL t4_data[%0d] got=%h exp=%h", k, r, e); end
        end
        last_read = e;
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        seen = 1'b0;
        cpu_req_rd = 0; cpu_req_wr = 1; cpu_req_sz = 2'd2; cpu_addr = 32'h40; cpu_data_out = 48'h0000_A1B2_C3D4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_we) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL t5_first_strobe got=none exp=strobe"); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        cpu_req_wr = 1'b0;
        model[16'h40] = 8'hD4;
        last_read = '0;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL t5_we_after_rst got=%0b exp=0", mem_we); end
        @(negedge clk);
        total++; if (cpu_data_in !== 48'h0 || cpu_enable !== 1'b0) begin bad++; $display("FAIL t5_outputs got=%h/%0b exp=0/0", cpu_data_in, cpu_enable); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[16'h40 + 16'(i)] !== model[16'h40 + 16'(i)]) begin
                bad++; $display("FAIL t5_ram[%0d] got=%h exp=%h", i, ram[16'h40 + 16'(i)], model[16'h40 + 16'(i)]);
            end
        end
        @(negedge clk);
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL t5_idle got=%0b exp=1", cpu_enable); end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_wr_priority();
        int st, wn, wb; logic [47:0] r, e; bit t;
        e = model_read(16'h7, 1);
        run_txn(1, 1, 2'd0, 32'h7, 48'h0000_0000_005A ^ {40'h0, model[16'h7]}, 0, st, wn, wb, r, t);
        total++; if (t || st != 3) begin bad++; $display("FAIL t6_stall got=%0d tmo=%0b exp=3", st, t); end
        total++; if (wn != 0 || wb != 0) begin bad++; $display("FAIL t6_we got=%0d/%0d exp=0/0", wn, wb); end
        total++; if (r !== e) begin bad++; $display("FAIL t6_data got=%h exp=%h", r, e); end
        total++; if (ram[16'h7] !== model[16'h7]) begin bad++; $display("FAIL t6_ram got=%h exp=%h", ram[16'h7], model[16'h7]); end
        last_read = e;
    endtask

    task automatic test_random();
        int st, wn, wb, n, errs; logic [47:0] r, e, d; bit t, rd, wr;
        logic [1:0] sz; logic [15:0] a;
        for (int k = 0; k < 40; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = 2'($urandom_range(0, 3));
            n  = nb(sz);
            a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'hF9)) : 16'($urandom_range(16'hFFF0, 16'hFFFF));
            d  = {16'($urandom), 32'($urandom)};
            e  = rd ? model_read(a, n) : last_read;
            run_txn(rd, wr, sz, {16'($urandom), a}, d, 0, st, wn, wb, r, t);
            total++;
            if (t || st != (rd ? n + 2 : n + 1) || wb != 0 || wn != (rd ? 0 : n)) begin
                bad++; $display("FAIL rnd_timing[%0d] stall=%0d we=%0d we_bad=%0d tmo=%0b rd=%0b n=%0d", k, st, wn, wb, t, rd, n);
            end
            total++;
            if (r !== e) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", k, r, e); end
            if (!rd) begin
                errs = 0;
                for (int i = 0; i < n && i < 8; i++) begin
                    if (obs_waddr[i] !== 16'(a + 16'(i)) || obs_wdat[i] !== d[8*i +: 8]) errs++;
                end
                total++;
                if (errs != 0) begin bad++; $display("FAIL rnd_wseq[%0d] got=%0d wrong bytes exp=0", k, errs); end
                model_write(a, n, d);
            end else begin
                last_read = e;
            end
        end
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[16'(i)] !== model[16'(i)]) errs++;
            if (ram[16'(16'hFF00 + i)] !== model[16'(16'hFF00 + i)]) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL ram_image got=%0d differing bytes exp=0", errs); end
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_req_rd = 1'b0; cpu_req_wr = 1'b0; cpu_req_sz = 2'd0;
        cpu_addr = '0; cpu_data_out = '0;
        last_read = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            poke(16'(i), 8'($urandom));
            poke(16'(16'hFF00 + i), 8'($urandom));
        end
        test_reset();
        test_read_32();
        test_write_16();
        test_wrap_48();
        test_back_to_back();
        test_reset_mid_write();
        test_rd_wr_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
